// File: rtl/branch_sequencer.sv
// branch_sequencer
// Program-counter controller between decode and instruction fetch. Owns the
// only copy of the PC. Branch requests are accepted over a valid/ready
// handshake, and their operands are captured. The condition is evaluated one
// cycle later on those captured operands. A taken branch redirects the PC and
// is followed by BUBBLES flush cycles.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   stall        fetch stall; freezes PC advance and acceptance in RUN
//   br_valid     branch request present
//   br_ready     request accepted when br_valid & br_ready
//   br_cond      3-bit condition code
//   br_value     signed operand tested by the condition
//   br_target    redirect address
//   pc           current fetch address (registered)
//   pc_valid     pc is a valid fetch address this cycle
//   taken        one-cycle pulse when a branch is taken (registered)
//   flush        high during flush bubbles (registered)
//   taken_count  saturating count of taken branches
module branch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0,
    parameter int BUBBLES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [DATA_W-1:0] br_value,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              taken,
    output logic              flush,
    output logic [7:0]        taken_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC_V  = ADDR_W'(RESET_PC);
    // Counter is loaded with BUBBLES-1 on entry so FLUSH lasts BUBBLES cycles.
    localparam logic [3:0]        BUBBLE_LAST = 4'(BUBBLES - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic                taken_reg, taken_next;
    logic                flush_reg, flush_next;
    logic [7:0]          count_reg, count_next;
    logic [2:0]          cond_reg, cond_next;
    logic [DATA_W-1:0]   value_reg, value_next;
    logic [ADDR_W-1:0]   target_reg, target_next;
    logic [3:0]          bubble_reg, bubble_next;

    logic                cond_true;
    logic                v_zero;
    logic                v_neg;

    // Condition decode on the captured operand only.
    assign v_zero = (value_reg == '0);
    assign v_neg  = value_reg[DATA_W-1];

    always_comb begin
        cond_true = 1'b0;
        case (cond_reg)
            3'b000:  cond_true = 1'b0;
            3'b001:  cond_true = v_zero;
            3'b010:  cond_true = v_neg;
            3'b011:  cond_true = v_neg | v_zero;
            3'b100:  cond_true = 1'b1;
            3'b101:  cond_true = ~v_zero;
            3'b110:  cond_true = ~v_neg;
            default: cond_true = ~v_neg & ~v_zero;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_RUN;
            pc_reg     <= RESET_PC_V;
            taken_reg  <= 1'b0;
            flush_reg  <= 1'b0;
            count_reg  <= 8'd0;
            cond_reg   <= 3'd0;
            value_reg  <= '0;
            target_reg <= '0;
            bubble_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            taken_reg  <= taken_next;
            flush_reg  <= flush_next;
            count_reg  <= count_next;
            cond_reg   <= cond_next;
            value_reg  <= value_next;
            target_reg <= target_next;
            bubble_reg <= bubble_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        taken_next  = 1'b0;
        flush_next  = flush_reg;
        count_next  = count_reg;
        cond_next   = cond_reg;
        value_next  = value_reg;
        target_next = target_reg;
        bubble_next = bubble_reg;
        br_ready    = 1'b0;
        pc_valid    = 1'b0;

        case (state_reg)
            ST_RUN: begin
                br_ready = ~stall;
                pc_valid = ~stall;
                if (!stall) begin
                    if (br_valid) begin
                        // PC holds on accept; it moves once the branch resolves.
                        cond_next   = br_cond;
                        value_next  = br_value;
                        target_next = br_target;
                        state_next  = ST_EVAL;
                    end else begin
                        pc_next = pc_reg + 1'b1;
                    end
                end
            end

            ST_EVAL: begin
                // Stall is deliberately ignored here: EVAL is always one cycle.
                if (cond_true) begin
                    pc_next    = target_reg;
                    taken_next = 1'b1;
                    if (count_reg != 8'hFF) begin
                        count_next = count_reg + 8'd1;
                    end
                    if (BUBBLES == 0) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next  = ST_FLUSH;
                        flush_next  = 1'b1;
                        bubble_next = BUBBLE_LAST;
                    end
                end else begin
                    pc_next    = pc_reg + 1'b1;
                    state_next = ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (bubble_reg == 4'd0) begin
                    state_next = ST_RUN;
                    flush_next = 1'b0;
                end else begin
                    bubble_next = bubble_reg - 4'd1;
                end
            end

            default: begin
                state_next = ST_RUN;
                flush_next = 1'b0;
            end
        endcase
    end

    assign pc          = pc_reg;
    assign taken       = taken_reg;
    assign flush       = flush_reg;
    assign taken_count = count_reg;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer. It uses directed and randomized
// branch traffic. The expected PC, taken and count values come from a
// transaction-level model: the condition is a signed integer comparison, a
// taken branch sets the PC to its target, and the flush window is BUBBLES cycles.
module tb_branch_sequencer;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int RESET_PC = 0;
    localparam int BUBBLES  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall;
    logic              br_valid;
    logic              br_ready;
    logic [2:0]        br_cond;
    logic [DATA_W-1:0] br_value;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              taken;
    logic              flush;
    logic [7:0]        taken_count;

    int                checks = 0;
    int                errors = 0;
    logic [ADDR_W-1:0] m_pc;
    int                m_count;

    always #5 clk = ~clk;

    branch_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC),
        .BUBBLES  (BUBBLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_cond     (br_cond),
        .br_value    (br_value),
        .br_target   (br_target),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .taken       (taken),
        .flush       (flush),
        .taken_count (taken_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Low two bits pick a base test; bit 2 negates it (never/always, ==0/!=0, <0/>=0, <=0/>0).
    function automatic bit model_taken(input logic [2:0] c, input logic [7:0] v);
        int sv;
        bit r;
        sv = int'($signed(v));
        case (c[1:0])
            2'd0:    r = 1'b0;
            2'd1:    r = (sv == 0);
            2'd2:    r = (sv < 0);
            default: r = (sv <= 0);
        endcase
        return c[2] ? !r : r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_cycles(input int n, input bit rand_stall);
        for (int i = 0; i < n; i++) begin
            stall    = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
            br_valid = 1'b0;
            #1;
            chk("run_pc", pc, m_pc);
            chk("run_pc_valid", pc_valid, !stall);
            chk("run_ready", br_ready, !stall);
            tick();
            if (!stall) m_pc = ADDR_W'((int'(m_pc) + 1) % 256);
            $display("run cycle: stall=%0b pc_next=%0h", stall, m_pc);
        end
        stall = 1'b0;
    endtask

    task automatic do_branch(input logic [2:0] c, input logic [7:0] v, input logic [7:0] t,
                             input int pre_stall, input bit flush_stall,
                             input bit poke_eval, input bit rst_in_flush);
        bit exp_t;
        bit has_flush;
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_cond   = c;
        br_value  = v;
        br_target = t;
        for (int i = 0; i < pre_stall; i++) begin
            #1;
            chk("hold_ready", br_ready, 0);
            chk("hold_pc_valid", pc_valid, 0);
            chk("hold_pc", pc, m_pc);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("acc_ready", br_ready, 1);
        chk("acc_pc", pc, m_pc);
        tick();
        // EVAL cycle: inputs may change freely without effect.
        br_valid = 1'b0;
        if (poke_eval) begin
            br_value  = 8'h05 ^ 8'($urandom_range(0, 1));
            br_cond   = 3'($urandom);
            br_target = 8'($urandom);
            stall     = 1'($urandom_range(0, 1));
        end
        #1;
        chk("eval_ready", br_ready, 0);
        chk("eval_pc_valid", pc_valid, 0);
        chk("eval_pc", pc, m_pc);
        chk("eval_taken", taken, 0);
        chk("eval_flush", flush, 0);
        tick();

        exp_t     = model_taken(c, v);
        has_flush = exp_t && (BUBBLES > 0);
        if (exp_t) begin
            m_pc = t;
            if (m_count < 255) m_count++;
        end else begin
            m_pc = ADDR_W'((int'(m_pc) + 1) % 256);
        end
        stall = (has_flush && flush_stall) ? 1'b1 : 1'b0;
        #1;
        chk("res_pc", pc, m_pc);
        chk("res_taken", taken, exp_t);
        chk("res_count", taken_count, m_count);
        chk("res_flush", flush, has_flush);
        chk("res_pc_valid", pc_valid, !has_flush);
        $display("branch: cond=%0b v=%0h tgt=%0h taken=%0b pc=%0h count=%0d",
                 c, v, t, exp_t, pc, taken_count);

        if (has_flush) begin
            if (rst_in_flush) begin
                stall = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_pc", pc, RESET_PC);
                chk("rst_flush", flush, 0);
                chk("rst_taken", taken, 0);
                chk("rst_count", taken_count, 0);
                chk("rst_ready", br_ready, 1);
                chk("rst_pc_valid", pc_valid, 1);
                #1;
                rst_n   = 1'b1;
                m_pc    = ADDR_W'(RESET_PC);
                m_count = 0;
                return;
            end
            for (int i = 1; i <= BUBBLES; i++) begin
                tick();
                stall = (i < BUBBLES) ? flush_stall : 1'b0;
                #1;
                chk("fl_pc", pc, m_pc);
                chk("fl_taken", taken, 0);
                chk("fl_flush", flush, (i < BUBBLES));
                chk("fl_pc_valid", pc_valid, (i == BUBBLES));
            end
        end
        stall = 1'b0;
    endtask

    logic [2:0] tc [11] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b011, 3'b000,
                            3'b100, 3'b101, 3'b110, 3'b111, 3'b111};
    logic [7:0] tv [11] = '{8'h00, 8'h80, 8'h7F, 8'h00, 8'h01, 8'h00,
                            8'h00, 8'hFF, 8'h80, 8'h01, 8'h80};

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_cond   = 3'd0;
        br_value  = 8'd0;
        br_target = 8'd0;
        m_pc      = ADDR_W'(RESET_PC);
        m_count   = 0;

        // Reset state.
        tick();
        tick();
        chk("reset_pc", pc, RESET_PC);
        chk("reset_taken", taken, 0);
        chk("reset_flush", flush, 0);
        chk("reset_count", taken_count, 0);
        chk("reset_ready", br_ready, 1);
        chk("reset_pc_valid", pc_valid, 1);
        rst_n = 1'b1;

        // Advance, asynchronous reset mid-count, advance again, wrap.
        run_cycles(5, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc, RESET_PC);
        rst_n = 1'b1;
        m_pc  = ADDR_W'(RESET_PC);
        run_cycles(4, 0);
        run_cycles(260, 0);

        // One case per condition code.
        for (int i = 0; i < 11; i++) begin
            do_branch(tc[i], tv[i], 8'($urandom), 0, 0, 0, 0);
            run_cycles(1, 0);
        end

        // Taken timing from pc=0x10 to 0x40.
        for (int i = 0; i < 256 && m_pc != 8'h10; i++) run_cycles(1, 0);
        do_branch(3'b100, 8'h00, 8'h40, 0, 0, 0, 0);
        run_cycles(2, 0);

        // Operand isolation: operand changes during EVAL.
        do_branch(3'b001, 8'h00, 8'hA5, 0, 0, 1, 0);

        // Stall hold before accept, and stall during FLUSH.
        do_branch(3'b100, 8'($urandom), 8'($urandom), 3, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            run_cycles($urandom_range(0, 3), 1);
            do_branch(3'($urandom), 8'($urandom), 8'($urandom),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        // Saturation of taken_count.
        for (int i = 0; i < 260; i++) begin
            do_branch(3'b100, 8'($urandom), 8'($urandom), 0, 0, 0, 0);
        end
        chk("sat_count", taken_count, 255);

        // Reset asserted during FLUSH, then normal advance from RESET_PC.
        do_branch(3'b100, 8'h00, 8'h77, 0, 0, 0, 1);
        run_cycles(3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter controller that sequences the conditional-check datapath for the TC CPU core. It accepts branch requests (3-bit condition code, 8-bit operand, target address) over a valid/ready handshake and evaluates the condition on registered operands. It then redirects or advances the PC and inserts a configurable flush bubble after a taken branch. It sits between the decode stage and instruction fetch, and it owns the only copy of the PC.

## Interface
- ADDR_W, 8, PC and target width
- DATA_W, 8, operand width; operand is two's-complement signed
- RESET_PC, 0, PC value on reset
- BUBBLES, 2, flush cycles after a taken branch (0..15)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  fetch stall; freezes PC advance in RUN
- br_valid  in  1  branch request present
- br_ready  out  1  request accepted when br_valid & br_ready
- br_cond  in  3  condition code
- br_value  in  DATA_W  operand tested by the condition
- br_target  in  ADDR_W  redirect address
- pc  out  ADDR_W  current fetch address
- pc_valid  out  1  pc is a valid fetch address this cycle
- taken  out  1  one-cycle pulse when a branch is taken
- flush  out  1  high during flush bubbles
- taken_count  out  8  saturating count of taken branches

## Operation
Condition codes, with the operand v treated as signed:
- 000 never; 001 v==0; 010 v<0 (MSB set); 011 v<=0
- 100 always; 101 v!=0; 110 v>=0; 111 v>0

States: RUN, EVAL, FLUSH.

RUN:
- br_ready = ~stall; pc_valid = ~stall.
- No accept and ~stall: pc <= pc+1, wrapping 2^ADDR_W-1 -> 0.
- stall: pc holds and no accept occurs.
- Accept: br_cond, br_value and br_target are captured into registers; pc holds; next state is EVAL.

EVAL (exactly 1 cycle, stall ignored):
- br_ready=0, pc_valid=0.
- The condition is evaluated on the captured operands only; later input changes have no effect.
- True: pc <= captured target; taken <= 1; taken_count increments, saturating at 255. Next state is FLUSH, or RUN if BUBBLES==0.
- False: pc <= pc+1, with wrap; next state is RUN.

FLUSH:
- br_ready=0, pc_valid=0, flush=1; pc holds the target.
- Internal counter runs BUBBLES cycles, then returns to RUN; stall does not extend FLUSH.

Other rules:
- br_valid held high while br_ready=0 is not consumed; it is accepted on the first RUN cycle with ~stall.
- Reset is asynchronous at any time, including mid-EVAL or mid-FLUSH. Reset values: state=RUN, pc=RESET_PC, taken=0, flush=0, taken_count=0, captured registers=0, bubble counter=0.
- Because outputs decode from state, br_ready and pc_valid equal ~stall immediately after reset.
- taken, flush and pc are registered; br_ready and pc_valid decode from state and stall.

## Timing
- Accept in cycle N with pc=P.
- Cycle N+1: EVAL; pc=P.
- Taken branch:
  - Cycle N+2: pc=target, taken=1 for that cycle only.
  - Cycles N+2 .. N+1+BUBBLES: flush=1.
  - Cycle N+2+BUBBLES: RUN, pc_valid=1 at target (if ~stall).
- Taken with BUBBLES=0: cycle N+2 is RUN at target with taken=1 and flush=0.
- Not taken: cycle N+2 is RUN, pc=P+1, taken=0.
- Back-to-back branches: earliest next accept is cycle N+2 (not taken) or N+2+BUBBLES (taken).
- taken_count is updated in the same cycle taken rises.

## Test plan
- Reset/advance: assert rst_n=0 mid-count, then release with stall=0 -> pc=0 and pc_valid=1; pc reads 1,2,3 on successive cycles; pc wraps 255->0.
- Each condition code, one case per code: v=0x00 with 001 -> taken; 0x80 with 010 -> taken; 0x7F with 010 -> not taken; 0x00 with 011 -> taken; 0x01 with 011 -> not taken; 000 -> never taken; 100 -> always taken; 0xFF with 101 -> taken; 0x80 with 110 -> not taken; 0x01 with 111 -> taken; 0x80 with 111 -> not taken.
- Taken timing, BUBBLES=2: accept at pc=0x10 with target 0x40 and cond 100 -> EVAL, then pc=0x40 with taken=1, flush=1 for 2 cycles, then pc_valid=1 at 0x40 and 0x41 next.
- Operand isolation: change br_value from 0x00 to 0x05 during EVAL with cond 001 -> branch still taken.
- Stall and hold: stall=1 with br_valid=1 -> br_ready=0 and pc frozen; drop stall -> accepted that cycle; stall during FLUSH -> FLUSH still lasts exactly 2 cycles.
- Saturation/reset: 260 taken branches -> taken_count=255; assert rst_n low during FLUSH -> pc=RESET_PC, flush=0, taken_count=0 immediately.
